// File: rtl/des_round_ctrl.sv
// Round sequencer for an iterative DES datapath: accepts a block, strobes ROUNDS
// round enables while stepping the C/D key schedule, then holds the result for downstream.
module des_round_ctrl #(
   parameter int ROUNDS = 16,
   parameter int KEY_W  = 56
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             decrypt_i,
   input  logic [KEY_W-1:0] key_cd_i,
   output logic             dp_load_o,
   output logic             round_en_o,
   output logic [3:0]       round_idx_o,
   output logic             first_round_o,
   output logic             last_round_o,
   output logic [KEY_W-1:0] cd_o,
   output logic             mode_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

   localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [KEY_W-1:0] cd_q, cd_d;
   logic             mode_q, mode_d;

   function automatic logic [1:0] shift_amt(input logic [3:0] i);
      case (i)
         4'd0, 4'd1, 4'd8, 4'd15: shift_amt = 2'd1;
         default:                 shift_amt = 2'd2;
      endcase
   endfunction

   // C and D halves rotate independently as 28-bit words.
   function automatic logic [KEY_W-1:0] rotl(input logic [KEY_W-1:0] v, input logic [1:0] s);
      logic [27:0] c, d;
      c = v[55:28];
      d = v[27:0];
      if (s == 2'd2) begin
         c = {c[25:0], c[27:26]};
         d = {d[25:0], d[27:26]};
      end else begin
         c = {c[26:0], c[27]};
         d = {d[26:0], d[27]};
      end
      rotl = {c, d};
   endfunction

   function automatic logic [KEY_W-1:0] rotr(input logic [KEY_W-1:0] v, input logic [1:0] s);
      logic [27:0] c, d;
      c = v[55:28];
      d = v[27:0];
      if (s == 2'd2) begin
         c = {c[1:0], c[27:2]};
         d = {d[1:0], d[27:2]};
      end else begin
         c = {c[0], c[27:1]};
         d = {d[0], d[27:1]};
      end
      rotr = {c, d};
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cd_d    = cd_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               state_d = S_ROUND;
               idx_d   = 4'd0;
               mode_d  = decrypt_i;
               // Decryption starts from K16, whose CD equals the unrotated CD0.
               cd_d    = decrypt_i ? key_cd_i : rotl(key_cd_i, shift_amt(4'd0));
            end
         end
         S_ROUND: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 4'd1;
               cd_d  = mode_q ? rotr(cd_q, shift_amt(4'd15 - idx_q))
                              : rotl(cd_q, shift_amt(idx_q + 4'd1));
            end
         end
         S_DONE: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         cd_q    <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cd_q    <= cd_d;
         mode_q  <= mode_d;
      end
   end

   // The load strobe is masked during reset since no accept can happen then.
   assign in_ready_o    = (state_q == S_IDLE);
   assign dp_load_o     = in_valid_i & in_ready_o & rst_ni;
   assign round_en_o    = (state_q == S_ROUND);
   assign round_idx_o   = idx_q;
   assign first_round_o = round_en_o & (idx_q == 4'd0);
   assign last_round_o  = round_en_o & (idx_q == LAST_IDX);
   assign cd_o          = cd_q;
   assign mode_o        = mode_q;
   assign out_valid_o   = (state_q == S_DONE);
   assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboard bench for des_round_ctrl: stimulus pushes the expected round/result stream,
// a negedge monitor pops and compares whenever the DUT strobes a round or hands off a result.
module tb_des_round_ctrl;

   localparam int ROUNDS = 16;
   localparam logic [55:0] KEY  = {28'hF0CCAAF, 28'h556678F};
   localparam logic [55:0] KEY1 = {28'hE19955F, 28'hAACCF1E};
   localparam logic [55:0] KEYD1 = {28'hF866557, 28'hAAB33C7};

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic        decrypt_i = 1'b0;
   logic [55:0] key_cd_i = '0;
   logic        dp_load_o;
   logic        round_en_o;
   logic [3:0]  round_idx_o;
   logic        first_round_o;
   logic        last_round_o;
   logic [55:0] cd_o;
   logic        mode_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic        busy_o;

   des_round_ctrl #(.ROUNDS(ROUNDS), .KEY_W(56)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .decrypt_i(decrypt_i), .key_cd_i(key_cd_i), .dp_load_o(dp_load_o),
      .round_en_o(round_en_o), .round_idx_o(round_idx_o), .first_round_o(first_round_o),
      .last_round_o(last_round_o), .cd_o(cd_o), .mode_o(mode_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  idx;
      logic [55:0] cd;
      logic        first;
      logic        last;
   } round_t;

   round_t rq[$];
   logic   resq[$];
   int     n_checks = 0;
   int     n_pass = 0;
   int     cyc = 0;
   int     load_cyc = 0;
   logic   prev_valid = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [27:0] rl28(input logic [27:0] x, input int s);
      logic [55:0] t;
      t = {x, x} >> (28 - (s % 28));
      return t[27:0];
   endfunction

   function automatic logic [27:0] rr28(input logic [27:0] x, input int s);
      logic [55:0] t;
      t = {x, x} >> (s % 28);
      return t[27:0];
   endfunction

   function automatic int shv(input int i);
      int tbl [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
      return tbl[i];
   endfunction

   // Expected CD at round i from cumulative shift totals, not iterated steps.
   function automatic logic [55:0] exp_cd(input logic dec, input logic [55:0] k, input int i);
      int s = 0;
      if (!dec) begin
         for (int j = 0; j <= i; j++) s += shv(j);
         return {rl28(k[55:28], s), rl28(k[27:0], s)};
      end
      for (int j = 16 - i; j <= 15; j++) s += shv(j);
      return {rr28(k[55:28], s), rr28(k[27:0], s)};
   endfunction

   task automatic push_block(input logic dec, input logic [55:0] k);
      round_t e;
      for (int i = 0; i < ROUNDS; i++) begin
         e.idx = 4'(i);
         e.cd = exp_cd(dec, k, i);
         if (k == KEY) begin
            if (!dec && i == 0) e.cd = KEY1;
            if (!dec && i == 15) e.cd = KEY;
            if (dec && i == 0) e.cd = KEY;
            if (dec && i == 1) e.cd = KEYD1;
            if (dec && i == 15) e.cd = KEY1;
         end
         e.first = (i == 0);
         e.last = (i == ROUNDS - 1);
         rq.push_back(e);
      end
      resq.push_back(dec);
   endtask

   always @(negedge clk_i) begin
      round_t e;
      logic m;
      cyc++;
      if (!rst_ni) begin
         prev_valid = 1'b0;
      end else begin
         if (dp_load_o) load_cyc = cyc;
         if (round_en_o) begin
            if (rq.size() == 0) begin
               check("round_unexpected", 1, 0);
            end else begin
               e = rq.pop_front();
               $display("round idx=%0d cd=%h first=%b last=%b", round_idx_o, cd_o, first_round_o, last_round_o);
               check("round_idx", round_idx_o, e.idx);
               check("round_cd", cd_o, e.cd);
               check("first_round", first_round_o, e.first);
               check("last_round", last_round_o, e.last);
            end
         end
         if (out_valid_o && !prev_valid) check("valid_latency", cyc - load_cyc, ROUNDS + 1);
         if (out_valid_o && out_ready_i) begin
            if (resq.size() == 0) begin
               check("result_unexpected", 1, 0);
            end else begin
               m = resq.pop_front();
               $display("result mode=%b", mode_o);
               check("result_mode", mode_o, m);
            end
         end
         prev_valid = out_valid_o;
      end
   end

   task automatic send(input logic dec, input logic [55:0] k);
      @(posedge clk_i); #1;
      in_valid_i = 1'b1; decrypt_i = dec; key_cd_i = k;
      push_block(dec, k);
      @(negedge clk_i);
      check("accept_ready", in_ready_o, 1);
      check("accept_load", dp_load_o, 1);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0; decrypt_i = ~dec; key_cd_i = ~k;
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk_i); n++;
      end while (!out_valid_o && n < 40);
      check("done_seen", out_valid_o, 1);
      if (out_ready_i) @(negedge clk_i);
   endtask

   task automatic wait_round(input int idx);
      int n = 0;
      while (!(round_en_o && round_idx_o == 4'(idx)) && n < 40) begin
         @(negedge clk_i); n++;
      end
      check("round_reached", round_idx_o, 4'(idx));
   endtask

   initial begin
      // Reset held three clocks with a pending request.
      in_valid_i = 1'b1;
      key_cd_i = KEY;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("rst_load", dp_load_o, 0);
         check("rst_ready", in_ready_o, 1);
         check("rst_valid", out_valid_o, 0);
         check("rst_cd", cd_o, 0);
         check("rst_round_en", round_en_o, 0);
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1; in_valid_i = 1'b0;

      // Encrypt and decrypt with the reference key.
      send(1'b0, KEY);
      wait_done();
      send(1'b1, KEY);
      wait_done();
      check("idle_ready", in_ready_o, 1);

      // Backpressure in DONE.
      out_ready_i = 1'b0;
      send(1'b0, KEY);
      wait_done();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         check("bp_valid", out_valid_o, 1);
         check("bp_ready", in_ready_o, 0);
         check("bp_idx", round_idx_o, 4'd15);
         check("bp_cd", cd_o, KEY);
      end
      @(posedge clk_i); #1;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      check("bp_hs_ready", in_ready_o, 0);
      @(negedge clk_i);
      check("bp_after_valid", out_valid_o, 0);
      check("bp_after_ready", in_ready_o, 1);

      // Request pulsed while busy must be ignored.
      send(1'b0, {28'h1234567, 28'h89ABCDE});
      wait_round(2);
      #1;
      in_valid_i = 1'b1; decrypt_i = 1'b1; key_cd_i = KEY;
      for (int i = 3; i <= 5; i++) begin
         @(negedge clk_i);
         check("busy_load", dp_load_o, 0);
         check("busy_ready", in_ready_o, 0);
         check("busy_flag", busy_o, 1);
      end
      #1;
      in_valid_i = 1'b0;
      wait_done();

      // Reset in the middle of the rounds.
      send(1'b0, KEY);
      wait_round(7);
      #1;
      rst_ni = 1'b0;
      @(negedge clk_i);
      check("mid_rst_round_en", round_en_o, 0);
      check("mid_rst_cd", cd_o, 0);
      check("mid_rst_ready", in_ready_o, 1);
      check("mid_rst_valid", out_valid_o, 0);
      rq.delete();
      resq.delete();
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      send(1'b0, KEY);
      wait_done();

      repeat (2) @(negedge clk_i);
      check("rq_drained", rq.size(), 0);
      check("resq_drained", resq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
